// File: rtl/definitions_pkg.sv
// Shared definitions for the Gaussian smoothing stage: fixed normalised
// kernels (3x3 and 5x5), their normalising shifts and lookup helpers.
package definitions_pkg;

    // Widest coefficient is 36 (5x5 centre), so 8 bits covers both kernels.
    localparam int GAUSS_COEF_W  = 32'sd8;

    // Kernel sums are 16 and 256, so normalising is a right shift.
    localparam int GAUSS_SHIFT_3 = 32'sd4;
    localparam int GAUSS_SHIFT_5 = 32'sd8;

    // outer([1 2 1]), row-major.
    localparam logic [7:0] gaussian_kernel_3 [0:8] = '{
        8'd1, 8'd2, 8'd1,
        8'd2, 8'd4, 8'd2,
        8'd1, 8'd2, 8'd1
    };

    // outer([1 4 6 4 1]), row-major.
    localparam logic [7:0] gaussian_kernel_5 [0:24] = '{
        8'd1,  8'd4,  8'd6,  8'd4,  8'd1,
        8'd4,  8'd16, 8'd24, 8'd16, 8'd4,
        8'd6,  8'd24, 8'd36, 8'd24, 8'd6,
        8'd4,  8'd16, 8'd24, 8'd16, 8'd4,
        8'd1,  8'd4,  8'd6,  8'd4,  8'd1
    };

    // Coefficient lookup; any out-of-range request yields zero weight.
    function automatic logic [7:0] gauss_coef(input int ksize, input int idx);
        logic [7:0] coef_v;
        coef_v = 8'd0;
        if ((ksize == 32'sd3) && (idx >= 32'sd0) && (idx < 32'sd9)) begin
            coef_v = gaussian_kernel_3[idx[3:0]];
        end else if ((ksize == 32'sd5) && (idx >= 32'sd0) && (idx < 32'sd25)) begin
            coef_v = gaussian_kernel_5[idx[4:0]];
        end else begin
            coef_v = 8'd0;
        end
        return coef_v;
    endfunction

    // Normalising shift for a given kernel edge length.
    function automatic int gauss_shift(input int ksize);
        int shift_v;
        if (ksize == 32'sd5) begin
            shift_v = GAUSS_SHIFT_5;
        end else begin
            shift_v = GAUSS_SHIFT_3;
        end
        return shift_v;
    endfunction

endpackage

// File: rtl/gaussian_adder_tree.sv
// Combinational pairwise reduction of N unsigned W-bit terms.
// The result is W+$clog2(N) bits wide, so no sum can overflow.
module gaussian_adder_tree
    import definitions_pkg::*;
#(
    parameter int N = 9,
    parameter int W = 12
) (
    input  logic [N*W-1:0]           in_terms,
    output logic [W+$clog2(N)-1:0]   out_sum
);

    localparam int OW  = W + $clog2(N);
    localparam int LVL = (N > 32'sd1) ? $clog2(N) : 32'sd0;
    localparam int TN  = 32'sd1 << LVL;

    // Pad to a power of two with zeros, then add neighbouring pairs level by level.
    always_comb begin : reduce
        logic [OW-1:0] node_v [TN];
        for (int i = 0; i < TN; i++) begin
            node_v[i] = (i < N) ? OW'(in_terms[i*W +: W]) : '0;
        end
        for (int s = TN / 2; s >= 1; s = s / 2) begin
            for (int i = 0; i < s; i++) begin
                node_v[i] = node_v[2*i] + node_v[2*i+1];
            end
        end
        out_sum = node_v[0];
    end

endmodule

// File: rtl/gaussian_filter_pipe.sv
// Gaussian smoothing stage: one KxK window in, one smoothed pixel out.
// Three register stages (MUL, SUM, NORM) share a single enable so that a
// stalled output freezes the whole pipe; bubbles are kept, not collapsed.
module gaussian_filter_pipe
    import definitions_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int KSIZE = 3
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  logic [KSIZE*KSIZE*PIX_W-1:0]    in_window,
    input  logic                            in_bypass,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [PIX_W-1:0]                out_pixel,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int NPIX  = KSIZE * KSIZE;
    localparam int CTR   = (NPIX - 32'sd1) / 32'sd2;
    localparam int SHIFT = gauss_shift(KSIZE);
    localparam int PW    = PIX_W + SHIFT;          // one product
    localparam int SW    = PW + 32'sd1;            // sum of all products
    localparam int TW    = PW + $clog2(NPIX);      // adder tree output

    // 2^(SHIFT-1) at sum width plus one carry bit: round half up.
    localparam logic [SW:0] HALF = {{(SW-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};

    // Parameter legality: anything else must stop elaboration.
    generate
        if ((KSIZE != 32'sd3) && (KSIZE != 32'sd5)) begin : g_bad_ksize
            $error("gaussian_filter_pipe: KSIZE must be 3 or 5");
        end
        if ((PIX_W < 32'sd4) || (PIX_W > 32'sd12)) begin : g_bad_pix_w
            $error("gaussian_filter_pipe: PIX_W must be in 4..12");
        end
    endgenerate

    logic                     en_s;
    logic [GAUSS_COEF_W-1:0]  coef_s [NPIX];

    // MUL stage registers
    logic [NPIX*PW-1:0]       prod_r;
    logic                     byp1_r;
    logic [PIX_W-1:0]         ctr1_r;
    logic                     v1_r;

    // SUM stage registers
    logic [TW-1:0]            tree_sum_s;
    logic [SW-1:0]            sum_r;
    logic                     ovf2_r;
    logic                     byp2_r;
    logic [PIX_W-1:0]         ctr2_r;
    logic                     v2_r;

    // NORM stage
    logic [SW:0]              rnd_s;
    logic                     sat_s;
    logic [PIX_W-1:0]         norm_s;
    logic [PIX_W-1:0]         out_pixel_r;
    logic                     out_valid_r;

    // Coefficients are constants chosen by kernel size at elaboration.
    generate
        if (KSIZE == 32'sd3) begin : g_k3
            for (genvar gi = 0; gi < NPIX; gi++) begin : g_coef
                assign coef_s[gi] = gaussian_kernel_3[gi];
            end
        end else if (KSIZE == 32'sd5) begin : g_k5
            for (genvar gi = 0; gi < NPIX; gi++) begin : g_coef
                assign coef_s[gi] = gaussian_kernel_5[gi];
            end
        end
    endgenerate

    // Global enable: the pipe advances unless a valid output is being refused.
    always_comb begin
        en_s     = !out_valid_r || out_ready;
        in_ready = en_s && rstN;
    end

    // MUL stage: per-tap products, with bypass flag and centre pixel carried along.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            prod_r <= '0;
            byp1_r <= 1'b0;
            ctr1_r <= '0;
            v1_r   <= 1'b0;
        end else if (en_s) begin
            for (int i = 0; i < NPIX; i++) begin
                prod_r[i*PW +: PW] <= PW'(coef_s[i]) * PW'(in_window[i*PIX_W +: PIX_W]);
            end
            byp1_r <= in_bypass;
            ctr1_r <= in_window[CTR*PIX_W +: PIX_W];
            v1_r   <= in_valid;
        end
    end

    gaussian_adder_tree #(
        .N (NPIX),
        .W (PW)
    ) u_adder_tree (
        .in_terms (prod_r),
        .out_sum  (tree_sum_s)
    );

    // SUM stage: full-precision sum; any bit above SW marks an impossible overflow.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            sum_r  <= '0;
            ovf2_r <= 1'b0;
            byp2_r <= 1'b0;
            ctr2_r <= '0;
            v2_r   <= 1'b0;
        end else if (en_s) begin
            sum_r  <= tree_sum_s[SW-1:0];
            ovf2_r <= |tree_sum_s[TW-1:SW];
            byp2_r <= byp1_r;
            ctr2_r <= ctr1_r;
            v2_r   <= v1_r;
        end
    end

    // NORM: round half up, shift down, clamp to full scale; bypass overrides all.
    always_comb begin
        rnd_s = ({1'b0, sum_r} + HALF) >> SHIFT;
        sat_s = ovf2_r || (|rnd_s[SW:PIX_W]);
        if (byp2_r) begin
            norm_s = ctr2_r;
        end else if (sat_s) begin
            norm_s = PIX_MAX;
        end else begin
            norm_s = rnd_s[PIX_W-1:0];
        end
    end

    // Output register: holds while the consumer refuses the pixel.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            out_pixel_r <= '0;
            out_valid_r <= 1'b0;
        end else if (en_s) begin
            out_pixel_r <= norm_s;
            out_valid_r <= v2_r;
        end
    end

    assign out_pixel = out_pixel_r;
    assign out_valid = out_valid_r;

endmodule
